// File: rtl/clock_switch_pkg.sv
// Shared encodings for the PLL reference-clock sequencer.
package clock_switch_pkg;

  // Sequencer states; the numeric values are visible on the status port.
  typedef enum logic [2:0] {
    ST_HOLD_RST  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Clock-mux source selects.
  localparam logic SRC_OSC  = 1'b0;  // on-board oscillator
  localparam logic SRC_LINK = 1'b1;  // recovered link clock

  localparam int TIMER_W = 20;
  localparam int RETRY_W = 4;

  // Saturating increment for the retry counter; MAX_RETRY caps it well
  // below the top code, so saturation is only a safety net.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the async level through STAGES flops; all clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_source_sequencer.sv
// Glitch-safe PLL reference switcher: holds the PLL in reset around every
// mux change, waits for lock with a timeout, requires a stable lock window,
// retries, and falls back to the oscillator if the link clock won't lock.
module clock_source_sequencer
  import clock_switch_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               switch_req,
  input  logic               sel_req,
  input  logic               pll_locked,
  output logic               clk_sel,
  output logic               pll_reset,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               lock_lost,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
);

  // Terminal counts for the shared timer, one per timed state.
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  state_e             st;
  logic [TIMER_W-1:0] timer;
  logic               lk;
  logic               attempt_fail;
  logic [RETRY_W-1:0] retry_nxt;

  // pll_locked comes from the PLL's own domain; every decision uses lk.
  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lk)
  );

  // An attempt dies on a WAIT_LOCK timeout (lock arriving the same cycle
  // wins) or on any drop of lock while settling.
  always_comb begin
    attempt_fail = 1'b0;
    if (st == ST_WAIT_LOCK && !lk && timer == TIMEOUT_LAST) attempt_fail = 1'b1;
    if (st == ST_SETTLE && !lk)                             attempt_fail = 1'b1;
  end

  assign retry_nxt = sat_inc(retry_cnt);
  assign state     = st;

  // Sequencer FSM; every output is registered so the mux select and PLL
  // reset can only move together on the edge that enters HOLD_RST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= ST_HOLD_RST;
      timer     <= '0;
      clk_sel   <= SRC_OSC;
      pll_reset <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
    end else begin
      done      <= 1'b0;
      lock_lost <= 1'b0;
      if (attempt_fail) begin
        timer     <= '0;
        pll_reset <= 1'b1;
        if (retry_nxt < RETRY_LIMIT) begin
          // Retry on the same source.
          st        <= ST_HOLD_RST;
          retry_cnt <= retry_nxt;
          busy      <= 1'b1;
        end else if (clk_sel == SRC_LINK) begin
          // Link clock exhausted its retries: fall back to the oscillator.
          st        <= ST_HOLD_RST;
          clk_sel   <= SRC_OSC;
          retry_cnt <= '0;
          fail      <= 1'b1;
          busy      <= 1'b1;
        end else begin
          // Oscillator will not lock either; park with the PLL held in reset.
          st        <= ST_FAULT;
          clk_sel   <= SRC_OSC;
          retry_cnt <= retry_nxt;
          fail      <= 1'b1;
          busy      <= 1'b0;
        end
      end else begin
        case (st)
          ST_HOLD_RST: begin
            if (timer == RST_LAST) begin
              st        <= ST_WAIT_LOCK;
              pll_reset <= 1'b0;
              timer     <= '0;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (lk) begin
              st    <= ST_SETTLE;
              timer <= '0;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_SETTLE: begin
            // lk is high here; a low lk was already taken as attempt_fail.
            if (timer == SETTLE_LAST) begin
              st    <= ST_LOCKED;
              done  <= 1'b1;
              busy  <= 1'b0;
              timer <= '0;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!lk) begin
              // Lock loss beats a coincident switch request, which is dropped.
              st        <= ST_HOLD_RST;
              lock_lost <= 1'b1;
              retry_cnt <= '0;
              pll_reset <= 1'b1;
              busy      <= 1'b1;
              timer     <= '0;
            end else if (switch_req) begin
              st        <= ST_HOLD_RST;
              clk_sel   <= sel_req;
              retry_cnt <= '0;
              fail      <= 1'b0;
              pll_reset <= 1'b1;
              busy      <= 1'b1;
              timer     <= '0;
            end
          end
          ST_FAULT: begin
            pll_reset <= 1'b1;
            if (switch_req) begin
              st        <= ST_HOLD_RST;
              clk_sel   <= sel_req;
              retry_cnt <= '0;
              fail      <= 1'b0;
              busy      <= 1'b1;
              timer     <= '0;
            end
          end
          default: begin
            st        <= ST_HOLD_RST;
            pll_reset <= 1'b1;
            busy      <= 1'b1;
            timer     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_source_sequencer.sv
// Directed bench for clock_source_sequencer with small timing parameters.
module tb_clock_source_sequencer;

  logic       clk = 1'b0;
  logic       reset, switch_req, sel_req, pll_locked;
  logic       clk_sel, pll_reset, busy, done, fail, lock_lost;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  int n_assert = 0, n_fail = 0;
  int done_cnt = 0, ll_cnt = 0;
  int n, rst_hi, done_idx;

  clock_source_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(8),
    .MAX_RETRY(2), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .switch_req(switch_req), .sel_req(sel_req),
    .pll_locked(pll_locked), .clk_sel(clk_sel), .pll_reset(pll_reset),
    .busy(busy), .done(done), .fail(fail), .lock_lost(lock_lost),
    .state(state), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and tally one-cycle pulses seen there.
  task automatic tick();
    @(negedge clk);
    if (done === 1'b1)      done_cnt++;
    if (lock_lost === 1'b1) ll_cnt++;
  endtask

  function automatic int sig(input int what);
    case (what)
      0:       return int'(state);
      1:       return int'(retry_cnt);
      2:       return int'(clk_sel);
      default: return int'(lock_lost);
    endcase
  endfunction

  // Tick until the selected signal equals val; cnt = ticks taken.
  task automatic wait_until(input string tag, input int what, input int val,
                            input int budget, output int cnt);
    cnt = 0;
    while (sig(what) != val && cnt < budget) begin
      tick();
      cnt++;
    end
    chk({tag, "_reached"}, 32'(sig(what) == val), 1);
  endtask

  initial begin
    reset = 1'b1; switch_req = 1'b0; sel_req = 1'b0; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 1);
    chk("rst_clk_sel", 32'(clk_sel), 0);
    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk("rst_retry", 32'(retry_cnt), 0);

    // Power-up acquisition of the oscillator with lock held high.
    reset = 1'b0; rst_hi = 0; done_idx = -1; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) tick();
      if (pll_reset === 1'b1) rst_hi++;
      if (done === 1'b1 && done_idx < 0) done_idx = i;
    end
    chk("pu_rst_cycles", 32'(rst_hi), 4);
    chk("pu_done_idx", 32'(done_idx), 13);
    chk("pu_done_cnt", 32'(done_cnt), 1);
    chk("pu_state", 32'(state), 4);
    chk("pu_busy", 32'(busy), 0);
    chk("pu_fail", 32'(fail), 0);
    chk("pu_clk_sel", 32'(clk_sel), 0);
    chk("pu_pll_reset", 32'(pll_reset), 0);

    // Switch to link clock; lock drops at the request, returns 10 cycles on.
    done_cnt = 0; ll_cnt = 0;
    switch_req = 1'b1; sel_req = 1'b1; pll_locked = 1'b0;
    tick(); switch_req = 1'b0;
    chk("sw1_clk_sel", 32'(clk_sel), 1);
    chk("sw1_pll_reset", 32'(pll_reset), 1);
    chk("sw1_state", 32'(state), 1);
    chk("sw1_busy", 32'(busy), 1);
    repeat (9) tick();
    pll_locked = 1'b1;
    wait_until("sw1_lock", 0, 4, 60, n);
    chk("sw1_lat", 32'(n), 11);
    chk("sw1_done_cnt", 32'(done_cnt), 1);
    chk("sw1_retry", 32'(retry_cnt), 0);
    chk("sw1_clk_sel_end", 32'(clk_sel), 1);
    chk("sw1_no_ll", 32'(ll_cnt), 0);

    // Link clock never locks: two timeouts, then fallback to oscillator.
    done_cnt = 0;
    switch_req = 1'b1; sel_req = 1'b1; pll_locked = 1'b0;
    tick(); switch_req = 1'b0;
    chk("fb_state0", 32'(state), 1);
    wait_until("fb_to1", 1, 1, 200, n);
    chk("fb_to1_cycles", 32'(n), 104);
    chk("fb_to1_clk_sel", 32'(clk_sel), 1);
    chk("fb_to1_pll_reset", 32'(pll_reset), 1);
    wait_until("fb_to2", 2, 0, 200, n);
    chk("fb_to2_cycles", 32'(n), 104);
    chk("fb_pll_reset", 32'(pll_reset), 1);
    chk("fb_fail", 32'(fail), 1);
    chk("fb_state", 32'(state), 1);
    chk("fb_retry", 32'(retry_cnt), 0);
    pll_locked = 1'b1;
    wait_until("fb_relock", 0, 4, 60, n);
    chk("fb_done_cnt", 32'(done_cnt), 1);
    chk("fb_fail_sticky", 32'(fail), 1);
    chk("fb_clk_sel_end", 32'(clk_sel), 0);

    // Oscillator never locks either: FAULT, then recover by request.
    switch_req = 1'b1; sel_req = 1'b0; pll_locked = 1'b0;
    tick(); switch_req = 1'b0;
    chk("ft_fail_clr", 32'(fail), 0);
    wait_until("ft_fault", 0, 5, 300, n);
    chk("ft_cycles", 32'(n), 208);
    chk("ft_pll_reset", 32'(pll_reset), 1);
    chk("ft_fail", 32'(fail), 1);
    chk("ft_busy", 32'(busy), 0);
    chk("ft_clk_sel", 32'(clk_sel), 0);
    chk("ft_retry", 32'(retry_cnt), 2);
    repeat (5) tick();
    chk("ft_stays", 32'(state), 5);
    done_cnt = 0;
    switch_req = 1'b1; sel_req = 1'b0; pll_locked = 1'b1;
    tick(); switch_req = 1'b0;
    chk("ft_exit_state", 32'(state), 1);
    wait_until("ft_relock", 0, 4, 40, n);
    chk("ft_relock_lat", 32'(n), 13);
    chk("ft_relock_fail", 32'(fail), 0);
    chk("ft_relock_done", 32'(done_cnt), 1);

    // One-cycle lock glitch while settling costs one retry.
    switch_req = 1'b1; sel_req = 1'b0;
    tick(); switch_req = 1'b0;
    wait_until("gs_settle", 0, 3, 20, n);
    chk("gs_settle_cycles", 32'(n), 5);
    tick(); tick();
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    wait_until("gs_retry", 0, 1, 10, n);
    chk("gs_retry_cycles", 32'(n), 2);
    chk("gs_retry_cnt", 32'(retry_cnt), 1);
    chk("gs_pll_reset", 32'(pll_reset), 1);
    chk("gs_clk_sel", 32'(clk_sel), 0);
    wait_until("gs_relock", 0, 4, 40, n);
    chk("gs_retry_held", 32'(retry_cnt), 1);

    // One-cycle lock glitch while locked: lock_lost pulse and relock.
    ll_cnt = 0;
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    wait_until("gl_pulse", 3, 1, 6, n);
    chk("gl_pulse_cycles", 32'(n), 2);
    chk("gl_state", 32'(state), 1);
    chk("gl_pll_reset", 32'(pll_reset), 1);
    chk("gl_retry", 32'(retry_cnt), 0);
    tick();
    chk("gl_pulse_width", 32'(lock_lost), 0);
    wait_until("gl_relock", 0, 4, 40, n);
    chk("gl_ll_cnt", 32'(ll_cnt), 1);
    chk("gl_retry_end", 32'(retry_cnt), 0);

    // Request while busy is dropped; then async reset in SETTLE.
    switch_req = 1'b1; sel_req = 1'b0; pll_locked = 1'b0;
    tick(); switch_req = 1'b0;
    wait_until("ig_to", 1, 1, 200, n);
    wait_until("ig_wait", 0, 2, 10, n);
    chk("ig_wait_cycles", 32'(n), 4);
    switch_req = 1'b1; sel_req = 1'b1;
    tick(); switch_req = 1'b0; sel_req = 1'b0;
    repeat (3) tick();
    chk("ig_clk_sel", 32'(clk_sel), 0);
    chk("ig_state", 32'(state), 2);
    chk("ig_busy", 32'(busy), 1);
    pll_locked = 1'b1;
    wait_until("ar_settle", 0, 3, 20, n);
    tick(); tick();
    chk("ar_pre_retry", 32'(retry_cnt), 1);
    chk("ar_pre_pll_reset", 32'(pll_reset), 0);
    reset = 1'b1;
    #1;
    chk("ar_state", 32'(state), 1);
    chk("ar_pll_reset", 32'(pll_reset), 1);
    chk("ar_busy", 32'(busy), 1);
    chk("ar_retry", 32'(retry_cnt), 0);
    chk("ar_clk_sel", 32'(clk_sel), 0);
    chk("ar_fail", 32'(fail), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_lock_lost", 32'(lock_lost), 0);
    tick(); reset = 1'b0;
    wait_until("ar_relock", 0, 4, 40, n);
    chk("ar_relock_lat", 32'(n), 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
